// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the mclk period monitor.
package clk_mon_pkg;

  localparam int CNT_W_DEF = 28;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  // Evaluated wider than any counter so exp+tol cannot overflow; lower bound clamps at zero.
  function automatic logic period_in_range(input logic [63:0] meas,
                                           input logic [63:0] exp_p,
                                           input logic [63:0] tol);
    logic [63:0] lo;
    logic [63:0] hi;
    lo = (exp_p >= tol) ? (exp_p - tol) : 64'd0;
    hi = exp_p + tol;
    return (meas >= lo) && (meas <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus an edge register
// giving fixed-latency rise/fall strobes.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign s_o    = sync2_q;
  assign rise_o = sync2_q & ~edge_q;
  assign fall_o = ~sync2_q & edge_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of a slow clock in inclk0 cycles, checks the
// period against EXP_PERIOD +/- TOL, and reports lock plus sticky errors.
//   state   | meaning
//   IDLE    | disabled, counters cleared, not locked
//   ARM     | waiting for the first rising edge of a measurement
//   MEASURE | counting between consecutive rising edges
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = 402,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 1024,
  parameter int LOCK_COUNT = 4
) (
  input  logic             inclk0,
  input  logic             rst,
  input  logic             mclk,
  input  logic             en,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             err_range,
  output logic             err_timeout
);

  localparam int              LK_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [LK_W-1:0]  LOCK_C    = LK_W'(LOCK_COUNT);

  logic s;
  logic rise;
  logic fall_unused;

  sync_edge_detect u_sync (
    .clk_i  (inclk0),
    .rst_i  (rst),
    .d_i    (mclk),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall_unused)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             err_range_q, err_range_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lock_cnt_d    = lock_cnt_q;
    locked_d      = locked_q;
    err_range_d   = err_range_q & ~clr_err;
    err_timeout_d = err_timeout_q & ~clr_err;
    period_d      = period_q;
    high_time_d   = high_time_q;
    valid_d       = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      hi_d       = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d    = '0;
          hi_d     = '0;
          locked_d = 1'b0;
          state_d  = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = ONE_C;
            hi_d    = ONE_C;
            state_d = MEASURE;
          end else if (cnt_q == TIMEOUT_C) begin
            err_timeout_d = 1'b1;
            locked_d      = 1'b0;
            lock_cnt_d    = '0;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still yields a normal measurement.
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_q;
            valid_d     = 1'b1;
            cnt_d       = ONE_C;
            hi_d        = ONE_C;
            if (period_in_range(64'(cnt_q), 64'(EXP_PERIOD), 64'(TOL))) begin
              if (lock_cnt_q != LOCK_C) lock_cnt_d = lock_cnt_q + LK_W'(1);
              if (lock_cnt_d == LOCK_C) locked_d = 1'b1;
            end else begin
              lock_cnt_d  = '0;
              locked_d    = 1'b0;
              err_range_d = 1'b1;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            err_timeout_d = 1'b1;
            locked_d      = 1'b0;
            lock_cnt_d    = '0;
            cnt_d         = '0;
            hi_d          = '0;
            state_d       = ARM;
          end else begin
            cnt_d = cnt_q + ONE_C;
            hi_d  = hi_q + CNT_W'(s);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge inclk0) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lock_cnt_q    <= '0;
      locked_q      <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lock_cnt_q    <= lock_cnt_d;
      locked_q      <= locked_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      valid_q       <= valid_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: stimulus pushes expected measurements,
// a negedge monitor pops and compares on every valid pulse.
module tb_clk_period_monitor;
  import clk_mon_pkg::*;

  localparam int CNT_W = 28;

  logic             inclk0 = 1'b0;
  logic             rst;
  logic             mclk;
  logic             en;
  logic             clr_err;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             err_range;
  logic             err_timeout;

  typedef struct {
    int   per;
    int   hi;
    logic lk;
    logic er;
    logic et;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   rise_cyc[32];
  int   valid_seen = 0;
  int   first_valid_cyc = 0;

  clk_period_monitor dut (
    .inclk0      (inclk0),
    .rst         (rst),
    .mclk        (mclk),
    .en          (en),
    .clr_err     (clr_err),
    .period      (period),
    .high_time   (high_time),
    .valid       (valid),
    .locked      (locked),
    .err_range   (err_range),
    .err_timeout (err_timeout)
  );

  always #5 inclk0 = ~inclk0;
  always @(posedge inclk0) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_valid: got period %0d, expected no valid (cycle %0d)", period, cyc);
    end else begin
      e = sb_q.pop_front();
      check("valid_period", period, e.per);
      check("valid_high_time", high_time, e.hi);
      check("valid_locked", locked, e.lk);
      check("valid_err_range", err_range, e.er);
      check("valid_err_timeout", err_timeout, e.et);
    end
  endtask

  always @(negedge inclk0) begin
    if (!rst && valid === 1'b1) begin
      if (valid_seen == 0) first_valid_cyc = cyc;
      valid_seen++;
      sb_compare();
    end
  end

  task automatic push(input int p, input int h, input logic lk, input logic er, input logic et);
    exp_t e;
    e.per = p; e.hi = h; e.lk = lk; e.er = er; e.et = et;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge inclk0);
      if (v && !mclk) begin
        rise_cnt++;
        if (rise_cnt < 32) rise_cyc[rise_cnt] = cyc;
      end
      mclk = v;
    end
  endtask

  task automatic gen(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge inclk0);
  endtask

  task automatic do_reset();
    @(negedge inclk0);
    rst = 1'b1; en = 1'b0; mclk = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge inclk0);
    rst = 1'b0;
    rise_cnt = 0;
    valid_seen = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr_err = 1'b0; mclk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge inclk0);
      check("reset_outputs", {period, high_time, valid, locked, err_range, err_timeout}, 64'd0);
      mclk = ~mclk;
    end

    // Nominal 201/201, then a fast 195/195 clock after lock.
    do_reset();
    for (int i = 0; i < 3; i++) push(402, 201, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(402, 201, 1'b1, 1'b0, 1'b0);
    push(390, 195, 1'b0, 1'b1, 1'b0);
    push(390, 195, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    drive(1'b0, 10);
    gen(201, 201, 6);
    gen(195, 195, 3);
    repeat (5) @(negedge inclk0);
    check("first_valid_latency", 64'(first_valid_cyc - rise_cyc[1]), 64'd405);
    check("nominal_drained", 64'(sb_q.size()), 64'd0);
    check("err_range_sticky", err_range, 1'b1);

    // Stuck-low clock after lock.
    do_reset();
    for (int i = 0; i < 3; i++) push(402, 201, 1'b0, 1'b0, 1'b0);
    push(402, 201, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    drive(1'b0, 10);
    gen(201, 201, 4);
    drive(1'b1, 201);
    drive(1'b0, 1);
    wait_until(rise_cyc[5] + 1026);
    check("timeout_not_early", err_timeout, 1'b0);
    check("locked_before_timeout", locked, 1'b1);
    @(negedge inclk0);
    check("timeout_set", err_timeout, 1'b1);
    check("timeout_unlock", locked, 1'b0);
    check("timeout_state_arm", dut.state_q, ARM);
    check("stuck_drained", 64'(sb_q.size()), 64'd0);

    // Enable drop 100 cycles after a rise, while locked.
    do_reset();
    for (int i = 0; i < 3; i++) push(402, 201, 1'b0, 1'b0, 1'b0);
    push(402, 201, 1'b1, 1'b0, 1'b0);
    push(402, 201, 1'b1, 1'b0, 1'b0);
    push(402, 201, 1'b0, 1'b0, 1'b0);
    push(402, 201, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    drive(1'b0, 10);
    fork
      gen(201, 201, 9);
      begin
        while (rise_cnt < 6) @(negedge inclk0);
        wait_until(rise_cyc[6] + 103);
        check("locked_before_drop", locked, 1'b1);
        en = 1'b0;
        @(negedge inclk0);
        check("locked_on_drop", locked, 1'b0);
        wait_until(rise_cyc[6] + 113);
        en = 1'b1;
      end
    join
    repeat (5) @(negedge inclk0);
    check("enable_drop_drained", 64'(sb_q.size()), 64'd0);

    // Range boundaries and clear/set collision.
    do_reset();
    push(404, 202, 1'b0, 1'b0, 1'b0);
    push(400, 200, 1'b0, 1'b0, 1'b0);
    push(405, 202, 1'b0, 1'b1, 1'b0);
    push(404, 202, 1'b0, 1'b0, 1'b0);
    push(405, 202, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    drive(1'b0, 10);
    fork
      begin
        gen(202, 202, 1);
        gen(200, 200, 1);
        gen(202, 203, 1);
        gen(202, 202, 1);
        gen(202, 203, 1);
        drive(1'b1, 10);
        drive(1'b0, 10);
      end
      begin
        while (rise_cnt < 4) @(negedge inclk0);
        wait_until(rise_cyc[4] + 100);
        check("err_before_clear", err_range, 1'b1);
        clr_err = 1'b1;
        @(negedge inclk0);
        clr_err = 1'b0;
        check("err_cleared", err_range, 1'b0);
        while (rise_cnt < 6) @(negedge inclk0);
        wait_until(rise_cyc[6] + 2);
        clr_err = 1'b1;
        @(negedge inclk0);
        clr_err = 1'b0;
      end
    join
    repeat (5) @(negedge inclk0);
    check("boundary_drained", 64'(sb_q.size()), 64'd0);
    check("err_set_wins", err_range, 1'b1);
    check("no_timeout_boundary", err_timeout, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Receive-side checker for a divided slow clock. It samples the slow clock `mclk` in the fast `inclk0` domain.
- It measures the period and high time of `mclk` in `inclk0` cycles and compares the period against an expected value with a tolerance.
- It reports lock status and sticky error flags.
- It sits next to the clock divider so software and testbenches can confirm the CPU clock is long and stable enough.

Parameters:
- CNT_W, 28: width of the period, high-time and internal counters.
- EXP_PERIOD, 402: expected `mclk` period in `inclk0` cycles.
- TOL, 2: allowed absolute deviation from EXP_PERIOD, inclusive.
- TIMEOUT, 1024: cycles without a rising edge before a timeout error. Must be less than 2^CNT_W.
- LOCK_COUNT, 4: consecutive in-range measurements needed to assert `locked`.

Ports:
- inclk0  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- mclk  in  1  monitored slow clock, treated as asynchronous data.
- en  in  1  monitor enable.
- clr_err  in  1  single-cycle clear of the sticky error flags.
- period  out  CNT_W  last measured rising-to-rising interval.
- high_time  out  CNT_W  `inclk0` cycles with synchronized `mclk` high within that interval.
- valid  out  1  one-cycle pulse; `period` and `high_time` updated.
- locked  out  1  stable in-range clock detected.
- err_range  out  1  sticky: a measured period was outside EXP_PERIOD±TOL.
- err_timeout  out  1  sticky: no rising edge within TIMEOUT cycles.

Behaviour:
- Reset: all outputs are 0. Synchronizer, edge register and counters are 0. State is IDLE.
- Front end:
  - Two-flop synchronizer produces `s`, then an edge register.
  - `rise` = s & ~s_d.
  - `mclk` to `rise` latency is 2–3 cycles and identical for every edge, so period measurement is exact.
- IDLE:
  - `cnt` = 0 and `locked` = 0.
  - Moves to ARM when `en`=1.
- ARM (wait for first edge):
  - `rise` → `cnt`<=1, `hi`<=1, go to MEASURE. No `valid`.
  - Otherwise `cnt`++.
  - If `cnt`==TIMEOUT: set `err_timeout`, `locked`<=0, `cnt`<=0, stay in ARM.
- MEASURE, on a cycle without `rise`:
  - `cnt`++.
  - `hi` += `s`.
  - If `cnt`==TIMEOUT: set `err_timeout`, `locked`<=0, go to ARM with `cnt`<=0. No `valid`.
- MEASURE, on `rise`:
  - Registered next cycle: `period`<=`cnt`, `high_time`<=`hi`, `valid`=1.
  - Restart: `cnt`<=1, `hi`<=1.
  - Range check: in range iff EXP_PERIOD−TOL <= `cnt` <= EXP_PERIOD+TOL. Compare with CNT_W+1-bit arithmetic; a lower bound below 0 clamps to 0.
  - In range: lock counter increments, saturating at LOCK_COUNT. `locked`<=1 when it reaches LOCK_COUNT.
  - Out of range: lock counter <=0, `locked`<=0, `err_range`<=1.
- Priority rules:
  - `rise` and `cnt`==TIMEOUT in the same cycle: `rise` wins, a normal measurement is taken, then the range check applies.
  - `en`=0 in any state: go to IDLE next cycle, `cnt`/`hi`/lock counter cleared, `locked`<=0. Any in-flight measurement is discarded with no `valid`. Sticky errors and `period`/`high_time` hold.
- Sticky errors:
  - Cleared only by `rst` or `clr_err`.
  - If `clr_err` and a new error occur in the same cycle, set wins.
- `rst` mid-measurement: everything returns to reset values on the next edge, including the synchronizer.
- Counters never wrap; the TIMEOUT check fires before overflow.

Decomposition:
- Package `clk_mon_pkg`:
  - state enum {IDLE, ARM, MEASURE}.
  - default CNT_W.
  - helper function for the in-range compare.
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus edge register. Outputs `s`, `rise`, `fall`. Has its own synchronous `rst`.

Test Plan:
- Reset: hold `rst` 3 cycles with `mclk` toggling. Required: all outputs 0, no `valid` while `rst`=1.
- Nominal: `mclk` 201 high / 201 low for 6 periods, `en`=1. Required:
  - first `valid` comes one period after the first `rise`;
  - `period`=402, `high_time`=201 on every `valid`;
  - `locked` rises with the 4th `valid`;
  - errors stay 0.
- Fast clock: after lock, switch to 195/195. Required: next `valid` has `period`=390, `locked`→0 and `err_range`=1 the same cycle, `err_range` stays 1.
- Stuck clock: after lock, hold `mclk` low. Required: `err_timeout`=1 and `locked`=0 exactly TIMEOUT=1024 cycles after the last `rise`, state ARM, no `valid`.
- Enable drop mid-period: deassert `en` 100 cycles after a `rise`, re-enable 10 cycles later. Required:
  - no `valid` for the aborted period;
  - `locked` 0 immediately;
  - the first new `valid` comes only after two further rises;
  - `period`=402.
- Boundaries:
  - period 404 (=EXP+TOL): in range, no error.
  - period 405: `err_range`.
  - `clr_err` in the same cycle as a 405 measurement: `err_range` remains 1.
